// File: rtl/mem_io_responder.sv
// Memory-mapped I/O responder: 256x16 RAM, LED register, synchronized switches
// and an 8-deep transmit FIFO, all read back with exactly one cycle of latency.
module mem_io_responder (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [15:0] TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY
);
    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_LED  = 4'h1;
    localparam logic [3:0] REG_SW   = 4'h3;
    localparam logic [3:0] REG_FIFO = 4'h4;
    localparam logic [3:0] REG_STAT = 4'h5;

    logic [15:0] ram [256];
    logic [15:0] fifo_mem [8];

    logic [15:0] din_q, din_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [9:0]  sw_meta_q, sw_meta_d;
    logic [9:0]  sw_sync_q, sw_sync_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  region;
    logic        full, empty, pop, push, fifo_wr, ovf_event;
    logic        ram_we, fifo_we;
    logic [15:0] rdata;

    always_comb begin
        region    = ADDR[15:12];
        full      = (count_q == 4'd8);
        empty     = (count_q == 4'd0);
        pop       = !empty && TX_READY;
        fifo_wr   = W && (region == REG_FIFO);
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push      = fifo_wr && (!full || pop);
        ovf_event = fifo_wr && full && !pop;
        ram_we    = Resetn && W && (region == REG_RAM);
        fifo_we   = Resetn && push;

        case (region)
            REG_RAM:  rdata = ram[ADDR[7:0]];
            REG_LED:  rdata = {6'b0, ledr_q};
            REG_SW:   rdata = {6'b0, sw_sync_q};
            REG_FIFO: rdata = fifo_mem[rd_ptr_q];
            REG_STAT: rdata = {9'b0, ovf_q, empty, full, count_q};
            default:  rdata = 16'h0000;
        endcase

        din_d     = rdata;
        ledr_d    = ledr_q;
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (!Resetn) begin
            din_d     = 16'h0000;
            ledr_d    = 10'h000;
            sw_meta_d = 10'h000;
            sw_sync_d = 10'h000;
            wr_ptr_d  = 3'd0;
            rd_ptr_d  = 3'd0;
            count_d   = 4'd0;
            ovf_d     = 1'b0;
        end else begin
            if (W && (region == REG_LED))
                ledr_d = DOUT[9:0];
            if (push)
                wr_ptr_d = wr_ptr_q + 3'd1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 3'd1;
            count_d = count_q + {3'b0, push} - {3'b0, pop};
            // A dropped push outranks a same-cycle clear.
            if (ovf_event)
                ovf_d = 1'b1;
            else if (W && (region == REG_STAT))
                ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        din_q     <= din_d;
        ledr_q    <= ledr_d;
        sw_meta_q <= sw_meta_d;
        sw_sync_q <= sw_sync_d;
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        count_q   <= count_d;
        ovf_q     <= ovf_d;
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge Clock) begin
        if (ram_we)
            ram[ADDR[7:0]] <= DOUT;
        if (fifo_we)
            fifo_mem[wr_ptr_q] <= DOUT;
    end

    assign DIN      = din_q;
    assign LEDR     = ledr_q;
    assign TX_DATA  = fifo_mem[rd_ptr_q];
    assign TX_VALID = (count_q != 4'd0);
endmodule
